mem_reader: RTL

Read-side sequencer for the 4-word × 6-bit register memory. It accepts a start command carrying a base address and a word count. It then drives `sel` through consecutive addresses, wrapping modulo 4, and captures `memout` after the memory's read latency. Each captured word is presented on a valid/ready output stream. It is the consumer counterpart of the `sel`/`memin`/`ld` writer path, and it never asserts a write.

---
 rtl/mem_reader_pkg.sv | 26 ++
 rtl/mem_reader_acc.sv | 31 +++
 rtl/mem_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: shared widths, FSM state encoding and count normalisation
// for the mem_reader read sequencer.
package mem_reader_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;
    localparam int SUM_W  = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT,
        DONE
    } mr_state_t;

    // 0 means a full sweep; anything above DEPTH saturates to DEPTH
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == '0 || c > CNT_W'(DEPTH)) r = CNT_W'(DEPTH);
        else                              r = c;
        return r;
    endfunction

endpackage

// File: rtl/mem_reader_acc.sv
// mem_reader_acc: running sum of words handed downstream. Cleared on each
// accepted command, accumulates the zero-extended word on each handshake.
module mem_reader_acc
    import mem_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [SUM_W-1:0]  sum
);

    logic [SUM_W-1:0] sum_q, sum_d;

    // next-sum: clear wins over add (they never coincide in practice)
    always_comb begin
        sum_d = sum_q;
        if (clr)      sum_d = '0;
        else if (add) sum_d = sum_q + SUM_W'(din);
    end

    // accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/mem_reader.sv
// mem_reader: read-side sequencer for the 4x6 register memory. Walks sel
// from base for count words (mod-4 wrap), waits RD_LAT cycles per word and
// presents each word on a valid/ready stream.
// Optional feature macro: MEM_READER_SUM_EN adds the `sum` output and the
// mem_reader_acc accumulator.
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] sel,
    input  logic [DATA_W-1:0] memout,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
`ifdef MEM_READER_SUM_EN
    ,
    output logic [SUM_W-1:0]  sum
`endif
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    mr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;

    assign hs = (state_q == OUT) && dout_valid_q && dout_ready;

    // next-state and next-output logic for the read sequencer
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rem_d        = rem_q;
        wcnt_d       = wcnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = base;
                    rem_d   = eff_count(count);
                    wcnt_d  = LAT;
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 2'd1;
                end else begin
                    dout_d       = memout;
                    dout_valid_d = 1'b1;
                    state_d      = OUT;
                end
            end
            OUT: begin
                if (hs) begin
                    dout_valid_d = 1'b0;
                    if (rem_q == CNT_W'(1)) begin
                        // done is registered here so it is high during DONE
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        rem_d   = rem_q - CNT_W'(1);
                        wcnt_d  = LAT;
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            rem_q        <= '0;
            wcnt_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rem_q        <= rem_d;
            wcnt_q       <= wcnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef MEM_READER_SUM_EN
    mem_reader_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr ((state_q == IDLE) && start),
        .add (hs),
        .din (dout_q),
        .sum (sum)
    );
`endif

endmodule
